// File: rtl/bus_demux_if.sv
// Bus-distributor handshake bundle: one shared input byte with select, and
// per-slot valid/ready toward the destination loads.
interface bus_demux_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SEL_BITS = 2
);
    localparam int unsigned NUM_OUT = 2 ** SEL_BITS;

    logic [WIDTH-1:0]         din;
    logic [SEL_BITS-1:0]      select;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OUT*WIDTH-1:0] dout;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;

    modport master (
        output din, select, in_valid, out_ready,
        input  in_ready, dout, out_valid
    );

    modport slave (
        input  din, select, in_valid, out_ready,
        output in_ready, dout, out_valid
    );
endinterface

// File: rtl/bus_demux.sv
// Bus distributor: steers one bus byte into one of 2**SEL_BITS holding slots,
// each with its own valid/ready drain, and counts accepted transfers.
module bus_demux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SEL_BITS = 2,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_demux_if.slave          bus,
    output logic [CNT_BITS-1:0] xfer_count
);
    localparam int unsigned NUM_OUT = 2 ** SEL_BITS;

    logic                     ready_c;
    logic                     accept_c;
    logic [NUM_OUT-1:0]       load_c;
    logic [NUM_OUT-1:0]       valid_q;
    logic [NUM_OUT*WIDTH-1:0] data_q;

    // Addressed slot can take a byte if empty or draining this same edge.
    assign ready_c  = rst_n & (~valid_q[bus.select] | bus.out_ready[bus.select]);
    assign accept_c = bus.in_valid & ready_c;

    assign bus.in_ready  = ready_c;
    assign bus.dout      = data_q;
    assign bus.out_valid = valid_q;

    always_comb begin
        load_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            load_c[i] = accept_c && (bus.select == SEL_BITS'(i));
        end
    end

    // Load wins over drain so a same-edge drain+accept keeps the slot valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (load_c[i]) begin
                    valid_q[i]                <= 1'b1;
                    data_q[i*WIDTH +: WIDTH]  <= bus.din;
                end else if (bus.out_ready[i]) begin
                    valid_q[i]                <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (accept_c) begin
            xfer_count <= xfer_count + CNT_BITS'(1);
        end
    end
endmodule

// File: tb/tb_bus_demux.sv
// Randomized and directed bench for bus_demux against a slot-array model.
module tb_bus_demux;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned SEL_BITS = 2;
    localparam int unsigned CNT_BITS = 8;
    localparam int unsigned NUM_OUT  = 4;

    logic                clk;
    logic                rst_n;
    logic [CNT_BITS-1:0] xfer_count;

    bus_demux_if #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus ();

    bus_demux #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot contents, occupancy flags and a transfer tally.
    int m_valid [NUM_OUT];
    int m_data  [NUM_OUT];
    int m_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_OUT; i++) begin
            m_valid[i] = 0;
            m_data[i]  = 0;
        end
        m_count = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_OUT-1:0] ev;
        ev = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            ev[i] = (m_valid[i] != 0);
            check_eq({tag, "_dout"}, 32'(bus.dout[i*WIDTH +: WIDTH]), 32'(m_data[i]));
        end
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ev));
        check_eq({tag, "_xfer_count"}, 32'(xfer_count), 32'(m_count));
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic cycle(input string tag, input logic iv, input int sel, input int d,
                         input logic [NUM_OUT-1:0] ordy);
        int exp_ready;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.select    = SEL_BITS'(sel);
        bus.din       = WIDTH'(d);
        bus.out_ready = ordy;
        #1;
        exp_ready = (m_valid[sel] == 0 || ordy[sel]) ? 1 : 0;
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
        @(posedge clk);
        for (int i = 0; i < NUM_OUT; i++)
            if (m_valid[i] != 0 && ordy[i]) m_valid[i] = 0;
        if (iv && exp_ready != 0) begin
            m_valid[sel] = 1;
            m_data[sel]  = d % 256;
            m_count      = (m_count + 1) % 256;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.select    = '0;
        bus.din       = '0;
        bus.out_ready = '0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < NUM_OUT; s++) begin
            @(negedge clk);
            bus.select = SEL_BITS'(s);
            #1;
            check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
        end
        check_outputs("idle");

        // Single delivery then drain; slot keeps its byte.
        cycle("single", 1'b1, 2, 'hA5, 4'b0000);
        check_eq("single_slot2", 32'(bus.dout[2*WIDTH +: WIDTH]), 32'hA5);
        check_eq("single_count", 32'(xfer_count), 32'd1);
        cycle("drain", 1'b0, 2, 0, 4'b0100);
        check_eq("drain_valid", 32'(bus.out_valid), 32'd0);
        check_eq("drain_keep", 32'(bus.dout[2*WIDTH +: WIDTH]), 32'hA5);

        // Back-pressure on slot 1, released by raising its out_ready.
        cycle("bp_fill", 1'b1, 1, 'h11, 4'b0000);
        for (int k = 0; k < 5; k++) cycle("bp_hold", 1'b1, 1, 'h22, 4'b0000);
        check_eq("bp_slot1_held", 32'(bus.dout[1*WIDTH +: WIDTH]), 32'h11);
        cycle("bp_release", 1'b1, 1, 'h22, 4'b0010);
        check_eq("bp_slot1_new", 32'(bus.dout[1*WIDTH +: WIDTH]), 32'h22);
        check_eq("bp_valid1", 32'(bus.out_valid[1]), 32'd1);

        // Parallel: slot1 blocked, accept to slot3 while slot0 drains.
        cycle("par_fill0", 1'b1, 0, 'h0F, 4'b0000);
        cycle("par", 1'b1, 3, 'h33, 4'b0001);
        check_eq("par_valid", 32'(bus.out_valid), 32'b1010);

        // Reach slots 0 and 2 valid with count 7, then reset mid-cycle.
        cycle("pre_rst0", 1'b1, 0, 'h40, 4'b1010);
        cycle("pre_rst2", 1'b1, 2, 'h42, 4'b0000);
        check_eq("pre_rst_count", 32'(xfer_count), 32'd7);
        idle_inputs();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 256 bytes with all consumers ready; count wraps to 0.
        for (int k = 0; k < 256; k++) cycle("stream", 1'b1, k % 4, k, 4'b1111);
        check_eq("stream_wrap", 32'(xfer_count), 32'd0);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), 4'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
